dac_ramp_envelope: RTL and testbench
====================================

# dac_ramp_envelope

Envelope stage in the DAC output path, sitting directly upstream of the output limiter. It multiplies the 16-bit signed waveform sample by a ramp factor that rises linearly from 0 to unity when enabled, holds at unity, and falls back to 0 when disabled. This lets the server switch excitation on and off without steps at the DAC. The scaled sample goes to the limiter's `signal_in`.

## Interface
- `ACC_W`, default 32: width of the ramp phase accumulator. Unity corresponds to 2^(ACC_W-1).
- `clk` input 1: single clock, DAC sample clock; all logic is on its rising edge.
- `rst` input 1: **synchronous, active-high reset**.
- `signal_in` input 16: signed two's-complement waveform sample, one per cycle.
- `ramp_enable` input 1: level. High requests ramp up/hold; low requests ramp down/idle.
- `ramp_inc` input ACC_W: unsigned per-cycle accumulator step. It is sampled every cycle and may change at any time.
- `signal_out` output 16: signed scaled sample, registered.
- `ramp_state` output 2: current state, encoded as 0 = IDLE, 1 = UP, 2 = HOLD, 3 = DOWN.
- `ramp_done` output 1: one-cycle pulse when a ramp-down reaches 0.
- `factor` output 16: current unsigned Q1.15 factor (0x8000 = 1.0), for status readback.

## Operation
- **Accumulator and factor**
  - `acc` is unsigned, ACC_W bits, and is clamped to the range [0, 2^(ACC_W-1)].
  - `factor = acc[ACC_W-1:ACC_W-16]`, so it spans 0x0000 to 0x8000.
- **State machine.** Only the transitions listed here occur; otherwise the state holds.
  - IDLE: `acc` = 0. If `ramp_enable`, go to UP.
  - UP, with `ramp_enable` high:
    - If `acc + ramp_inc >= 2^(ACC_W-1)`, set `acc` to unity and go to HOLD.
    - Otherwise `acc += ramp_inc`.
  - UP, with `ramp_enable` low: go to DOWN with `acc` unchanged that cycle. There is no jump in the factor.
  - HOLD: `acc` = unity. If `!ramp_enable`, go to DOWN.
  - DOWN, with `ramp_enable` low:
    - If `acc <= ramp_inc`, set `acc` = 0, go to IDLE, and pulse `ramp_done`.
    - Otherwise `acc -= ramp_inc`.
  - DOWN, with `ramp_enable` high: go to UP with `acc` unchanged.
- **`ramp_inc` = 0.** This means no ramp.
  - UP goes to HOLD with `acc` = unity in the same update.
  - DOWN goes to IDLE with `acc` = 0 and pulses `ramp_done`.
- **Overflow.** The add is computed at ACC_W+1 bits, so no wrap-around is possible.
- **Arithmetic**
  - The product `signal_in * $signed({1'b0,factor})` is 33 bits signed.
  - `signal_out = product >>> 15`: arithmetic shift, truncating toward minus infinity.
  - The result always fits in 16 bits because |factor| ≤ 1.0, so no saturation is needed.
  - With factor 0x8000 the output is bit-exact to the input, including -32768.
- **Reset**
  - On reset: state IDLE, `acc` 0, `signal_out` 0x0000, `factor` 0x0000, `ramp_done` 0, and the pipeline registers cleared.
  - Reset asserted mid-ramp forces all of the above on the next edge, regardless of `ramp_enable`.

## Timing
- **Pipeline**
  - Stage 1 registers `signal_in` and `factor`.
  - Stage 2 registers the shifted product into `signal_out`.
  - Latency from `signal_in` to `signal_out` is 2 cycles, using the factor that was current when the sample entered.
- **Factor update.** A change in `ramp_enable` moves `ramp_state` at the next edge. The first accumulator step is applied on the edge after that.
- **Ramp length.** The ramp lasts ceil(2^(ACC_W-1) / `ramp_inc`) cycles in UP, and the same in DOWN.
- **`ramp_done` alignment.** It is asserted in the same cycle that `ramp_state` first reads IDLE.
- **Throughput.** One sample per cycle, with no stalls and no handshake.

## Test plan
- **Reset with signal present.** Assert `rst` with `signal_in` = 0x4000 and `ramp_enable` = 1 → `signal_out` = 0, `factor` = 0, `ramp_state` = 0 for as long as `rst` is held.
- **Full ramp up.** `ramp_inc` = 0x0100_0000, `signal_in` = 0x7FFF, `ramp_enable` rises →
  - `factor` increments by 0x0100 per cycle.
  - HOLD is reached after 128 UP cycles.
  - `signal_out` = 0x7FFF two cycles after the factor reaches 0x8000.
- **Ramp down from HOLD.** `signal_in` = -32768 (0x8000), drop `ramp_enable` →
  - The factor reaches 0 after 128 cycles.
  - `ramp_done` pulses exactly once.
  - `signal_out` settles to 0 two cycles later.
- **Reversal mid-ramp.** Drop `ramp_enable` when `factor` = 0x4000 → the next factor values are 0x4000 then 0x3F00. There is no discontinuity, and `ramp_done` stays 0 until the factor reaches 0.
- **Zero increment.** `ramp_inc` = 0 with `signal_in` = 0x1234 →
  - The factor goes 0 → 0x8000 one cycle after entering UP.
  - `signal_out` = 0x1234.
  - Disable → `ramp_done` pulses on the next update.
- **Rounding and uneven final step.** Set `signal_in` = -1 at factor 0x4000 → `signal_out` = -1, showing truncation toward minus infinity. Separately, with `ramp_inc` = 0x7000_0000 → UP reaches unity on its 2nd step, clamped rather than wrapping.

Source files
------------

// File: rtl/dac_ramp_envelope.sv
// Envelope stage ahead of the DAC limiter: scales each sample by a linear 0..1.0 ramp
// so excitation can be switched on and off without steps at the output.
module dac_ramp_envelope #(
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [15:0]      signal_in,
  input  logic                    ramp_enable,
  input  logic        [ACC_W-1:0] ramp_inc,
  output logic signed [15:0]      signal_out,
  output logic        [1:0]       ramp_state,
  output logic                    ramp_done,
  output logic        [15:0]      factor
);

  // state | meaning
  // IDLE  | factor held at 0, waiting for enable
  // UP    | factor rising by ramp_inc per cycle
  // HOLD  | factor held at unity
  // DOWN  | factor falling by ramp_inc per cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_HOLD = 2'd2,
    ST_DOWN = 2'd3
  } state_e;

  localparam logic [ACC_W-1:0] UNITY     = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W:0]   UNITY_EXT = {1'b0, UNITY};

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               done_q, done_d;
  logic [ACC_W:0]     sum;
  logic               inc_zero;

  logic signed [15:0] sig_s1_q;
  logic        [15:0] fac_s1_q;
  logic signed [15:0] out_q, out_d;
  logic signed [32:0] sig_ext, fac_ext, prod;
  logic               unused_prod;

  // one extra bit on the add so a large step can never wrap past unity
  assign sum      = {1'b0, acc_q} + {1'b0, ramp_inc};
  assign inc_zero = (ramp_inc == '0);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        if (ramp_enable) state_d = ST_UP;
      end
      ST_UP: begin
        if (!ramp_enable) begin
          state_d = ST_DOWN;
        end else if (inc_zero || (sum >= UNITY_EXT)) begin
          acc_d   = UNITY;
          state_d = ST_HOLD;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
      end
      ST_HOLD: begin
        acc_d = UNITY;
        if (!ramp_enable) state_d = ST_DOWN;
      end
      ST_DOWN: begin
        if (ramp_enable) begin
          state_d = ST_UP;
        end else if (inc_zero || (acc_q <= ramp_inc)) begin
          acc_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          acc_d = acc_q - ramp_inc;
        end
      end
    endcase
  end

  // factor is non-negative, so it is zero-extended before the signed multiply
  assign sig_ext = {{17{sig_s1_q[15]}}, sig_s1_q};
  assign fac_ext = {17'd0, fac_s1_q};
  assign prod    = sig_ext * fac_ext;
  assign out_d   = prod[30:15];
  assign unused_prod = ^{prod[32:31], prod[14:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      done_q   <= 1'b0;
      sig_s1_q <= '0;
      fac_s1_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      sig_s1_q <= signal_in;
      fac_s1_q <= factor;
      out_q    <= out_d;
    end
  end

  assign factor     = acc_q[ACC_W-1 -: 16];
  assign ramp_state = state_q;
  assign ramp_done  = done_q;
  assign signal_out = out_q;

endmodule

// File: tb/tb_dac_ramp_envelope.sv
// Self-checking bench for dac_ramp_envelope: vector table, directed ramp sequences
// and a randomized run, all compared against an arithmetic reference model.
module tb_dac_ramp_envelope;

  localparam int ACC_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       signal_in;
  logic              ramp_enable;
  logic [ACC_W-1:0]  ramp_inc;
  logic [15:0]       signal_out;
  logic [1:0]        ramp_state;
  logic              ramp_done;
  logic [15:0]       factor;

  int n_cmp = 0;
  int n_err = 0;

  dac_ramp_envelope #(.ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .signal_in  (signal_in),
    .ramp_enable(ramp_enable),
    .ramp_inc   (ramp_inc),
    .signal_out (signal_out),
    .ramp_state (ramp_state),
    .ramp_done  (ramp_done),
    .factor     (factor)
  );

  always #5 clk = ~clk;

  // reference model: accumulator as a plain integer, samples in a 2-deep delay line
  int          m_state;
  longint      m_acc;
  logic        m_done;
  int          m_s1_sig;
  longint      m_s1_fac;
  logic [15:0] m_out;

  function automatic longint floor_div32768(input longint p);
    if (p >= 0) return p / 32768;
    return -((-p + 32767) / 32768);
  endfunction

  task automatic model_step();
    longint unity, inc;
    unity = longint'(1) << (ACC_W - 1);
    inc   = longint'(ramp_inc);
    if (rst) begin
      m_state = 0; m_acc = 0; m_done = 1'b0;
      m_s1_sig = 0; m_s1_fac = 0; m_out = 16'h0000;
    end else begin
      m_out    = 16'(floor_div32768(longint'(m_s1_sig) * m_s1_fac));
      m_s1_sig = int'($signed(signal_in));
      m_s1_fac = m_acc >> (ACC_W - 16);
      m_done   = 1'b0;
      if (m_state == 0) begin
        m_acc = 0;
        if (ramp_enable) m_state = 1;
      end else if (m_state == 1) begin
        if (!ramp_enable) m_state = 3;
        else if (inc == 0 || m_acc + inc >= unity) begin m_acc = unity; m_state = 2; end
        else m_acc = m_acc + inc;
      end else if (m_state == 2) begin
        m_acc = unity;
        if (!ramp_enable) m_state = 3;
      end else begin
        if (ramp_enable) m_state = 1;
        else if (inc == 0 || m_acc <= inc) begin m_acc = 0; m_state = 0; m_done = 1'b1; end
        else m_acc = m_acc - inc;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_state",  {30'd0, ramp_state}, 32'(m_state));
    check("model_factor", {16'd0, factor},     {16'd0, 16'(m_acc >> (ACC_W - 16))});
    check("model_done",   {31'd0, ramp_done},  {31'd0, m_done});
    check("model_out",    {16'd0, signal_out}, {16'd0, m_out});
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] inc;
    logic [15:0] sig;
    logic [1:0]  exp_state;
    logic [15:0] exp_factor;
    logic        exp_done;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int up_cnt, dn_cnt, done_cnt, early_done, g;
    logic [15:0] f_prev;

    // reset rows hold signal and enable active; zero-increment rows follow
    vecs[0]  = '{1'b1, 1'b1, 32'h0,         16'h4000, 2'd0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 32'h0,         16'h4000, 2'd0, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 32'h0,         16'h4000, 2'd0, 16'h0000, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 32'h0,         16'h1234, 2'd1, 16'h0000, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 32'h0,         16'h1234, 2'd2, 16'h8000, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 32'h0,         16'h1234, 2'd2, 16'h8000, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 32'h0,         16'h1234, 2'd2, 16'h8000, 1'b0, 16'h1234};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         16'h1234, 2'd3, 16'h8000, 1'b0, 16'h1234};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         16'h1234, 2'd0, 16'h0000, 1'b1, 16'h1234};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         16'h1234, 2'd0, 16'h0000, 1'b0, 16'h1234};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         16'h1234, 2'd0, 16'h0000, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 32'h0100_0000, 16'h1234, 2'd0, 16'h0000, 1'b0, 16'h0000};

    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; ramp_enable = vecs[i].en;
      ramp_inc = vecs[i].inc; signal_in = vecs[i].sig;
      tick();
      check($sformatf("vec%0d_state", i),  {30'd0, ramp_state}, {30'd0, vecs[i].exp_state});
      check($sformatf("vec%0d_factor", i), {16'd0, factor},     {16'd0, vecs[i].exp_factor});
      check($sformatf("vec%0d_done", i),   {31'd0, ramp_done},  {31'd0, vecs[i].exp_done});
      check($sformatf("vec%0d_out", i),    {16'd0, signal_out}, {16'd0, vecs[i].exp_out});
    end

    // full ramp up: 128 UP cycles, +0x0100 per step
    signal_in = 16'h7FFF; ramp_inc = 32'h0100_0000; ramp_enable = 1'b1;
    tick();
    check("up_entry", {30'd0, ramp_state}, 32'd1);
    up_cnt = 0; g = 0;
    while (ramp_state == 2'd1 && g < 400) begin
      up_cnt++; f_prev = factor;
      tick(); g++;
      check("up_step", {16'd0, factor}, {16'd0, f_prev + 16'h0100});
    end
    if (g >= 400) timeout("up_wait");
    check("up_cycles", 32'(up_cnt), 32'd128);
    check("hold_reached", {30'd0, ramp_state}, 32'd2);
    tick(); tick();
    check("out_unity", {16'd0, signal_out}, 32'h0000_7FFF);

    // ramp down from HOLD with the most negative sample
    signal_in = 16'h8000;
    tick(); tick(); tick();
    check("out_neg_full", {16'd0, signal_out}, 32'h0000_8000);
    ramp_enable = 1'b0;
    tick();
    dn_cnt = 0; done_cnt = 0; g = 0;
    while (ramp_state == 2'd3 && g < 400) begin
      dn_cnt++;
      tick(); g++;
      if (ramp_done) done_cnt++;
    end
    if (g >= 400) timeout("down_wait");
    check("down_cycles", 32'(dn_cnt), 32'd128);
    check("down_factor0", {16'd0, factor}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ramp_done) done_cnt++;
    end
    check("down_done_pulses", 32'(done_cnt), 32'd1);
    check("down_out_zero", {16'd0, signal_out}, 32'd0);

    // reversal at factor 0x4000, also shows -1 * 0.5 truncating to -1
    signal_in = 16'hFFFF; ramp_enable = 1'b1;
    g = 0;
    tick();
    while (factor != 16'h4000 && g < 400) begin tick(); g++; end
    if (g >= 400) timeout("rev_wait");
    ramp_enable = 1'b0;
    tick();
    check("rev_f0", {16'd0, factor}, 32'h0000_4000);
    check("rev_state", {30'd0, ramp_state}, 32'd3);
    tick();
    check("rev_f1", {16'd0, factor}, 32'h0000_3F00);
    check("round_neg1", {16'd0, signal_out}, 32'h0000_FFFF);
    early_done = 0; done_cnt = 0; g = 0;
    while (ramp_state != 2'd0 && g < 400) begin
      tick(); g++;
      if (ramp_done && factor != 16'h0000) early_done++;
      if (ramp_done) done_cnt++;
    end
    if (g >= 400) timeout("rev_idle_wait");
    check("rev_no_early_done", 32'(early_done), 32'd0);
    check("rev_done_once", 32'(done_cnt), 32'd1);

    // uneven final step clamps to unity on the 2nd step
    ramp_inc = 32'h7000_0000; ramp_enable = 1'b1;
    tick();
    tick();
    check("big_step1", {16'd0, factor}, 32'h0000_7000);
    tick();
    check("big_step2", {16'd0, factor}, 32'h0000_8000);
    check("big_hold", {30'd0, ramp_state}, 32'd2);

    // reset mid-ramp with enable still high
    ramp_enable = 1'b0; ramp_inc = 32'h0100_0000;
    for (int k = 0; k < 20; k++) tick();
    ramp_enable = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_state", {30'd0, ramp_state}, 32'd0);
    check("mid_rst_factor", {16'd0, factor}, 32'd0);
    check("mid_rst_out", {16'd0, signal_out}, 32'd0);
    tick();
    rst = 1'b0;

    // randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 59) == 0) ramp_enable = ~ramp_enable;
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 4))
          0: ramp_inc = 32'h0;
          1: ramp_inc = 32'h0100_0000;
          2: ramp_inc = 32'($urandom_range(1, 32'h0400_0000));
          3: ramp_inc = $urandom;
          default: ramp_inc = 32'h7000_0000;
        endcase
      end
      signal_in = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
